// File: rtl/mux_scan.sv
// mux_scan: time-multiplexed round-robin scanner for CHANNELS words of WIDTH bits.
// A prescaler divides clk into slots. At each slot boundary the selection
// steps to the next channel enabled in ch_mask. The chosen word and a one-hot,
// active-low digit enable are registered on every edge.
// Optional feature: define MUX_SCAN_BLANK_EN to force 'an' high while
// cnt < BLANK_CYCLES. This gives an anti-ghosting dead time at the start of
// every slot.

module mux_scan #(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 4,
  parameter int SEL_W        = 2,
  parameter int PRESCALE     = 100000,
  parameter int CNT_W        = 17,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [0:CHANNELS*WIDTH-1] in_bus,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic                      en,
  input  logic                      hold,
  output logic [0:WIDTH-1]          out,
  output logic [CHANNELS-1:0]       an,
  output logic [SEL_W-1:0]          sel,
  output logic                      tick
);

  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]    CNT_BLANK  = CNT_W'(BLANK_CYCLES);
  localparam logic [SEL_W:0]      SEL_LIMIT  = (SEL_W + 1)'(CHANNELS);
  localparam logic [CHANNELS-1:0] ONE_HOT_0  = CHANNELS'(1);

`ifdef MUX_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    next_sel;
  logic [0:WIDTH-1]    word_sel;
  logic [CHANNELS-1:0] an_next;
  logic                sel_valid;
  logic                blank_active;
  logic                scan_found;
  int                  scan_base;
  int                  scan_idx;

  // A forced, out-of-range sel restarts the search just below channel 0.
  assign sel_valid = ({1'b0, sel} < SEL_LIMIT);

  // Dead time at the start of a slot. It is constant-false unless blanking is built in.
  assign blank_active = BLANK_ON && (cnt < CNT_BLANK);

  // Search sel+1, sel+2, ... (wrapping) for the next enabled channel; sel itself is tried last.
  always_comb begin
    next_sel   = sel;
    scan_found = 1'b0;
    scan_idx   = 0;
    scan_base  = sel_valid ? int'(sel) : -1;
    for (int k = 1; k <= CHANNELS; k++) begin
      scan_idx = scan_base + k;
      if (scan_idx >= CHANNELS) begin
        scan_idx = scan_idx - CHANNELS;
      end
      if (!scan_found && |(ch_mask & (ONE_HOT_0 << scan_idx))) begin
        next_sel   = SEL_W'(scan_idx);
        scan_found = 1'b1;
      end
    end
  end

  // Pick the word for the current sel and build its enable; a masked-off channel stays dark.
  always_comb begin
    word_sel = '0;
    an_next  = '1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        word_sel = in_bus[k*WIDTH +: WIDTH];
        if (ch_mask[k]) begin
          an_next = ~(ONE_HOT_0 << k);
        end
      end
    end
  end

  // Prescaler and selection. Both freeze when en is low. A slot ends with a tick, and sel moves on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
      sel  <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
      if (tick && !hold) begin
        sel <= next_sel;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Registered outputs track sel on every edge regardless of en, one cycle behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      an  <= '1;
    end else begin
      out <= word_sel;
      an  <= blank_active ? '1 : an_next;
    end
  end

endmodule
